response_collector: RTL and testbench

RESPONSE_COLLECTOR -- requirements
Module: response_collector

---
 rtl/puf_pkg.sv | 20 ++
 rtl/freq_regfile.sv | 53 +++++
 rtl/response_collector.sv | 143 ++++++++++++++
 tb/tb_response_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : puf_pkg
// Brief    : Shared TERO-PUF defaults and the response collector state type.
// Revision : 1.0
// ============================================================================
package puf_pkg;

    localparam int unsigned c_NUM_LOOPS        = 4;
    localparam int unsigned c_COUNT_BITS       = 32;
    localparam int unsigned c_LOG2_REPETITIONS = 12;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPARE = 2'd1,
        ST_OUTPUT  = 2'd2
    } collector_state_t;

endpackage : puf_pkg
`default_nettype wire

// File: rtl/freq_regfile.sv
`default_nettype none
// ============================================================================
// Module   : freq_regfile
// Brief    : Per-loop average frequency store with loaded flags, one write
//            port and two combinational read ports.
// Revision : 1.0
// ============================================================================
module freq_regfile #(
    parameter int NUM_LOOPS = 4,
    parameter int FREQ_BITS = 20,
    parameter int SEL_BITS  = $clog2(NUM_LOOPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [SEL_BITS-1:0]  wr_idx,
    input  logic [FREQ_BITS-1:0] wr_data,
    input  logic                 clr_loaded,
    input  logic [SEL_BITS-1:0]  rd_idx_a,
    input  logic [SEL_BITS-1:0]  rd_idx_b,
    output logic [FREQ_BITS-1:0] rd_data_a,
    output logic [FREQ_BITS-1:0] rd_data_b,
    output logic [NUM_LOOPS-1:0] loaded
);

    logic [FREQ_BITS-1:0] r_freq [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] r_loaded;

    // Entries keep their last value across collections; only loaded is cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                r_freq[i] <= '0;
            end
            r_loaded <= '0;
        end else begin
            if (wr_en) begin
                r_freq[wr_idx] <= wr_data;
            end
            if (clr_loaded) begin
                r_loaded <= '0;
            end else if (wr_en) begin
                r_loaded[wr_idx] <= 1'b1;
            end
        end
    end

    assign rd_data_a = r_freq[rd_idx_a];
    assign rd_data_b = r_freq[rd_idx_b];
    assign loaded    = r_loaded;

endmodule : freq_regfile
`default_nettype wire

// File: rtl/response_collector.sv
`default_nettype none
// ============================================================================
// Module   : response_collector
// Brief    : Collects per-loop TERO averages, compares loop pairs into PUF
//            response bits and hands them off with sticky error flags.
// Revision : 1.0
// ============================================================================
module response_collector
    import puf_pkg::*;
#(
    parameter int NUM_LOOPS        = c_NUM_LOOPS,
    parameter int COUNT_BITS       = c_COUNT_BITS,
    parameter int LOG2_REPETITIONS = c_LOG2_REPETITIONS,
    parameter int FREQ_BITS        = COUNT_BITS - LOG2_REPETITIONS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COUNT_BITS-1:0]        count_in,
    input  logic [$clog2(NUM_LOOPS)-1:0] select_puf,
    input  logic                         store_response_puf,
    input  logic                         fsm_done,
    output logic [NUM_LOOPS/2-1:0]       response,
    output logic                         response_valid,
    input  logic                         response_ready,
    output logic                         err_incomplete,
    output logic                         err_dup,
    output logic                         err_overrun
);

    localparam int c_SEL_BITS  = $clog2(NUM_LOOPS);
    localparam int c_PAIRS     = NUM_LOOPS / 2;
    localparam int c_PAIR_BITS = (c_PAIRS > 1) ? $clog2(c_PAIRS) : 1;

    collector_state_t       r_state, w_state_next;
    logic                   r_done_d, r_done_armed, r_done_rise;
    logic [c_PAIR_BITS-1:0] r_pair_idx;
    logic [c_PAIRS-1:0]     r_response;
    logic                   r_err_incomplete, r_err_dup, r_err_overrun;

    logic                   w_sel_ok, w_dup_hit, w_wr_en, w_last_pair, w_handshake;
    logic [c_SEL_BITS-1:0]  w_idx_a, w_idx_b;
    logic [FREQ_BITS-1:0]   w_freq_a, w_freq_b;
    logic [NUM_LOOPS-1:0]   w_loaded, w_wr_mask, w_loaded_after;
    logic                   w_count_unused;

    assign w_sel_ok       = ({1'b0, select_puf} < (c_SEL_BITS + 1)'(NUM_LOOPS));
    assign w_dup_hit      = w_sel_ok ? w_loaded[select_puf] : 1'b1;
    assign w_wr_en        = store_response_puf && (r_state == ST_COLLECT) && w_sel_ok;
    assign w_wr_mask      = w_wr_en ? (NUM_LOOPS'(1) << select_puf) : '0;
    assign w_loaded_after = w_loaded | w_wr_mask;
    assign w_idx_a        = c_SEL_BITS'({r_pair_idx, 1'b0});
    assign w_idx_b        = c_SEL_BITS'({r_pair_idx, 1'b1});
    assign w_last_pair    = (r_pair_idx == c_PAIR_BITS'(c_PAIRS - 1));
    assign w_handshake    = (r_state == ST_OUTPUT) && response_ready;
    assign w_count_unused = ^count_in[LOG2_REPETITIONS-1:0];

    freq_regfile #(
        .NUM_LOOPS (NUM_LOOPS),
        .FREQ_BITS (FREQ_BITS),
        .SEL_BITS  (c_SEL_BITS)
    ) u_freq_regfile (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (w_wr_en),
        .wr_idx     (select_puf),
        .wr_data    (count_in[COUNT_BITS-1:LOG2_REPETITIONS]),
        .clr_loaded (w_handshake),
        .rd_idx_a   (w_idx_a),
        .rd_idx_b   (w_idx_b),
        .rd_data_a  (w_freq_a),
        .rd_data_b  (w_freq_b),
        .loaded     (w_loaded)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: if (r_done_rise) w_state_next = ST_COMPARE;
            ST_COMPARE: if (w_last_pair) w_state_next = ST_OUTPUT;
            ST_OUTPUT:  if (w_handshake) w_state_next = ST_COLLECT;
            default:    w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_COLLECT;
            r_done_d         <= 1'b0;
            r_done_armed     <= 1'b0;
            r_done_rise      <= 1'b0;
            r_pair_idx       <= '0;
            r_response       <= '0;
            r_err_incomplete <= 1'b0;
            r_err_dup        <= 1'b0;
            r_err_overrun    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done_d <= fsm_done;
            // A done level held through reset must drop once before it can trigger.
            if (!fsm_done) begin
                r_done_armed <= 1'b1;
            end
            r_done_rise <= fsm_done && !r_done_d && r_done_armed;

            case (r_state)
                ST_COLLECT: begin
                    if (store_response_puf && w_dup_hit) begin
                        r_err_dup <= 1'b1;
                    end
                    if (r_done_rise) begin
                        r_pair_idx       <= '0;
                        r_err_incomplete <= ~&w_loaded_after;
                    end
                end
                ST_COMPARE: begin
                    r_response[r_pair_idx] <= (w_freq_a > w_freq_b);
                    r_pair_idx             <= r_pair_idx + c_PAIR_BITS'(1);
                    if (store_response_puf) begin
                        r_err_overrun <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (w_handshake) begin
                        r_err_incomplete <= 1'b0;
                        r_err_dup        <= 1'b0;
                        r_err_overrun    <= 1'b0;
                    end else if (store_response_puf) begin
                        r_err_overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign response       = r_response;
    assign response_valid = (r_state == ST_OUTPUT);
    assign err_incomplete = r_err_incomplete;
    assign err_dup        = r_err_dup;
    assign err_overrun    = r_err_overrun;

endmodule : response_collector
`default_nettype wire

// File: tb/tb_response_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_response_collector
// Brief    : Scoreboard bench for response_collector.
// Revision : 1.0
// ============================================================================
module tb_response_collector;

    localparam int NL = 4;
    localparam int CB = 32;
    localparam int LR = 12;
    localparam int FB = CB - LR;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CB-1:0] count_in = '0;
    logic [1:0]    select_puf = '0;
    logic          store_response_puf = 1'b0;
    logic          fsm_done = 1'b0;
    logic          response_ready = 1'b0;
    logic [NL/2-1:0] response;
    logic          response_valid;
    logic          err_incomplete, err_dup, err_overrun;

    response_collector #(
        .NUM_LOOPS        (NL),
        .COUNT_BITS       (CB),
        .LOG2_REPETITIONS (LR)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .count_in           (count_in),
        .select_puf         (select_puf),
        .store_response_puf (store_response_puf),
        .fsm_done           (fsm_done),
        .response           (response),
        .response_valid     (response_valid),
        .response_ready     (response_ready),
        .err_incomplete     (err_incomplete),
        .err_dup            (err_dup),
        .err_overrun        (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL/2-1:0] resp;
        logic            inc;
        logic            dup;
    } exp_t;

    exp_t          sb_q[$];
    logic [FB-1:0] m_freq [NL];
    logic [NL-1:0] m_loaded;
    logic          m_dup;
    int            n_vectors = 0;
    int            n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int p = 0; p < NL / 2; p++) begin
            e.resp[p] = (m_freq[2*p] > m_freq[2*p+1]);
        end
        e.inc = ~&m_loaded;
        e.dup = m_dup;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic strobe(input int idx, input logic [31:0] val, input bit with_done);
        select_puf         = idx[1:0];
        count_in           = val;
        store_response_puf = 1'b1;
        if (m_loaded[idx]) m_dup = 1'b1;
        m_freq[idx]   = val[CB-1:LR];
        m_loaded[idx] = 1'b1;
        if (with_done) begin
            fsm_done = 1'b1;
            push_expected();
        end
        @(negedge clk);
        store_response_puf = 1'b0;
    endtask

    task automatic raise_done();
        fsm_done = 1'b1;
        push_expected();
    endtask

    task automatic wait_response(input string tag, input int exp_cycles);
        int   cycles = 0;
        exp_t e;
        while (!response_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!response_valid) begin
            check({tag, "_timeout"}, 32'(response_valid), 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_resp"}, 32'(response), 32'(e.resp));
        check({tag, "_incomplete"}, 32'(err_incomplete), 32'(e.inc));
        check({tag, "_dup"}, 32'(err_dup), 32'(e.dup));
        check({tag, "_overrun"}, 32'(err_overrun), 32'd0);
    endtask

    task automatic handshake(input string tag);
        response_ready = 1'b1;
        @(negedge clk);
        response_ready = 1'b0;
        fsm_done       = 1'b0;
        check({tag, "_hs_valid"}, 32'(response_valid), 32'd0);
        check({tag, "_hs_flags"}, {29'd0, err_incomplete, err_dup, err_overrun}, 32'd0);
        m_loaded = '0;
        m_dup    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL/2-1:0] held;
        bit              seen;
        for (int i = 0; i < NL; i++) m_freq[i] = '0;
        m_loaded = '0;
        m_dup    = 1'b0;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_response", 32'(response), 32'd0);
        check("rst_valid", 32'(response_valid), 32'd0);
        check("rst_flags", {29'd0, err_incomplete, err_dup, err_overrun}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Full load, no errors
        strobe(0, 32'h00A00000, 0);
        strobe(1, 32'h00900000, 0);
        strobe(2, 32'h00500000, 0);
        strobe(3, 32'h00600000, 0);
        raise_done();
        wait_response("basic", 2 + NL / 2);
        handshake("basic");

        // Loop 3 left unloaded; its stored value from the previous run remains
        strobe(0, 32'h00A00000, 0);
        strobe(1, 32'h00900000, 0);
        strobe(2, 32'h00500000, 0);
        raise_done();
        wait_response("incomplete", 2 + NL / 2);
        handshake("incomplete");

        // Duplicate write overwrites
        strobe(0, 32'h00A00000, 0);
        strobe(1, 32'h00900000, 0);
        strobe(1, 32'h01000000, 0);
        strobe(2, 32'h00500000, 0);
        strobe(3, 32'h00600000, 0);
        raise_done();
        wait_response("dup", 2 + NL / 2);
        check("dup_freq1", 32'(dut.u_freq_regfile.r_freq[1]), 32'h1000);
        handshake("dup");

        // Tie gives 0; last strobe coincides with the done rise
        strobe(0, 32'h00800000, 0);
        strobe(1, 32'h00800000, 0);
        strobe(2, 32'h00700000, 0);
        strobe(3, 32'h00100000, 1);
        wait_response("tie", 1 + NL / 2);
        handshake("tie");

        // Backpressure with a strobe during OUTPUT
        strobe(0, 32'h00300000, 0);
        strobe(1, 32'h00400000, 0);
        strobe(2, 32'h00900000, 0);
        strobe(3, 32'h00200000, 0);
        raise_done();
        wait_response("hold", 2 + NL / 2);
        held = response;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(response_valid), 32'd1);
            check("hold_resp", 32'(response), 32'(held));
        end
        select_puf         = 2'd0;
        count_in           = 32'h0FFFF000;
        store_response_puf = 1'b1;
        @(negedge clk);
        store_response_puf = 1'b0;
        check("overrun_flag", 32'(err_overrun), 32'd1);
        check("overrun_resp", 32'(response), 32'(held));
        check("overrun_valid", 32'(response_valid), 32'd1);
        handshake("overrun");

        // Reset in the middle of COMPARE, done kept high across it
        strobe(0, 32'h00A00000, 0);
        strobe(1, 32'h00900000, 0);
        strobe(2, 32'h00500000, 0);
        strobe(3, 32'h00600000, 0);
        raise_done();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_response", 32'(response), 32'd0);
        check("midrst_valid", 32'(response_valid), 32'd0);
        check("midrst_flags", {29'd0, err_incomplete, err_dup, err_overrun}, 32'd0);
        void'(sb_q.pop_back());
        for (int i = 0; i < NL; i++) m_freq[i] = '0;
        m_loaded = '0;
        m_dup    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (response_valid) seen = 1'b1;
        end
        check("held_done_no_valid", 32'(seen), 32'd0);
        fsm_done = 1'b0;
        @(negedge clk);
        raise_done();
        wait_response("after_rst", 2 + NL / 2);
        handshake("after_rst");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_response_collector
`default_nettype wire
